// File: rtl/sdram_pro_arbiter.sv
// sdram_pro_arbiter
//
// Shares one SDRAM command/data port between the initialisation sequencer,
// the auto-refresh engine and one write and one read burst engine.
//
// After reset the init_* command bus drives the SDRAM until init_end is seen.
// From then on a single idle state (ARB) grants the bus to one channel at a
// time. Refresh always wins. Between write and read, PRIO_MODE selects fixed
// write-over-read (0) or alternation on ties (1). A granted channel keeps the
// bus until its *_end pulse arrives, or until TIMEOUT cycles have passed. On a
// timeout the sticky arb_err flag is raised.
//
// Ports
//   sys_clk, sys_rst                  clock, synchronous active-high reset
//   init_cmd/bank/addr, init_end      initialisation command bus and done level
//   atref_req/end, atref_cmd/bank/addr refresh request, done pulse, command bus
//   wr_req/end, wr_sdram_cmd/bank/addr write request, done pulse, command bus
//   wr_sdram_en, wr_sdram_data        write data valid and write data
//   rd_req/end, rd_sdram_cmd/bank/addr read request, done pulse, command bus
//   atref_en, wr_en, rd_en            per-channel grant
//   sdram_cmd/bank/addr               muxed SDRAM command bus
//   sdram_dq_out, sdram_dq_oe         write data and tristate enable
//   arb_err                           sticky timeout flag
module sdram_pro_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int BANK_W    = 2,
  parameter int DATA_W    = 16,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              atref_req,
  input  logic              atref_end,
  input  logic [3:0]        atref_cmd,
  input  logic [BANK_W-1:0] atref_bank,
  input  logic [ADDR_W-1:0] atref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_sdram_cmd,
  input  logic [BANK_W-1:0] wr_sdram_bank,
  input  logic [ADDR_W-1:0] wr_sdram_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_sdram_cmd,
  input  logic [BANK_W-1:0] rd_sdram_bank,
  input  logic [ADDR_W-1:0] rd_sdram_addr,
  output logic              atref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [3:0]        sdram_cmd,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe,
  output logic              arb_err
);

  localparam logic [3:0] CMD_NOP = 4'b0111;

  // The counter only has to reach TIMEOUT-1 before the timeout fires.
  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARB   = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             rr_wr_first;  // 1: write wins the next write/read tie
  logic             set_err;
  logic             grant;
  logic             busy;
  logic             tie_to_read;

  // Only alternation mode ever lets read win a tie.
  assign tie_to_read = (PRIO_MODE == 1) && !rr_wr_first;

  assign busy  = (state == ST_AREF) || (state == ST_WRITE) || (state == ST_READ);
  assign grant = (state == ST_ARB) && (next_state != ST_ARB);

  // Next-state logic. A channel's *_end is only looked at in its own state,
  // so stray end pulses from other engines fall through untouched.
  always_comb begin
    next_state = state;
    set_err    = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_end) next_state = ST_ARB;
      end
      ST_ARB: begin
        if (atref_req)                next_state = ST_AREF;
        else if (wr_req && rd_req)    next_state = tie_to_read ? ST_READ : ST_WRITE;
        else if (wr_req)              next_state = ST_WRITE;
        else if (rd_req)              next_state = ST_READ;
      end
      ST_AREF: begin
        if (atref_end) next_state = ST_ARB;
        else if (cnt == CNT_LAST) begin
          next_state = ST_ARB;
          set_err    = 1'b1;
        end
      end
      ST_WRITE: begin
        if (wr_end) next_state = ST_ARB;
        else if (cnt == CNT_LAST) begin
          next_state = ST_ARB;
          set_err    = 1'b1;
        end
      end
      ST_READ: begin
        if (rd_end) next_state = ST_ARB;
        else if (cnt == CNT_LAST) begin
          next_state = ST_ARB;
          set_err    = 1'b1;
        end
      end
      default: next_state = ST_INIT;
    endcase
  end

  // State register, hold counter, alternation pointer and sticky error.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_INIT;
      cnt         <= '0;
      rr_wr_first <= 1'b1;
      arb_err     <= 1'b0;
    end else begin
      state <= next_state;
      if (grant || !busy) cnt <= '0;
      else                cnt <= cnt + 1'b1;
      if (grant && (next_state == ST_WRITE)) rr_wr_first <= 1'b0;
      if (grant && (next_state == ST_READ))  rr_wr_first <= 1'b1;
      if (set_err) arb_err <= 1'b1;
    end
  end

  // Output mux decoded from the state register only, so a channel's command
  // reaches the SDRAM pins in the same cycle it is presented.
  always_comb begin
    atref_en   = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    sdram_cmd  = CMD_NOP;
    sdram_bank = '0;
    sdram_addr = '0;
    case (state)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_bank = init_bank;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        atref_en   = 1'b1;
        sdram_cmd  = atref_cmd;
        sdram_bank = atref_bank;
        sdram_addr = atref_addr;
      end
      ST_WRITE: begin
        wr_en      = 1'b1;
        sdram_cmd  = wr_sdram_cmd;
        sdram_bank = wr_sdram_bank;
        sdram_addr = wr_sdram_addr;
      end
      ST_READ: begin
        rd_en      = 1'b1;
        sdram_cmd  = rd_sdram_cmd;
        sdram_bank = rd_sdram_bank;
        sdram_addr = rd_sdram_addr;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_bank = '0;
        sdram_addr = '0;
      end
    endcase
  end

  assign sdram_dq_out = wr_sdram_data;
  assign sdram_dq_oe  = (state == ST_WRITE) && wr_sdram_en;

endmodule

// File: tb/tb_sdram_pro_arbiter.sv
module tb_sdram_pro_arbiter;

  localparam int ADDR_W = 12;
  localparam int BANK_W = 2;
  localparam int DATA_W = 16;

  localparam logic [17:0] BUS_INIT = {4'b0010, 2'd1, 12'h400};
  localparam logic [17:0] BUS_NOP  = {4'b0111, 2'd0, 12'h000};
  localparam logic [17:0] BUS_AREF = {4'b0001, 2'd2, 12'h0A5};
  localparam logic [17:0] BUS_WR   = {4'b0100, 2'd3, 12'h123};
  localparam logic [17:0] BUS_RD   = {4'b0101, 2'd1, 12'h321};

  // stat = {atref_en, wr_en, rd_en, arb_err}
  localparam logic [3:0] S_IDLE = 4'b0000;
  localparam logic [3:0] S_AREF = 4'b1000;
  localparam logic [3:0] S_WR   = 4'b0100;
  localparam logic [3:0] S_RD   = 4'b0010;
  localparam logic [3:0] S_ERR  = 4'b0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              sys_rst = 1'b1;
  logic [3:0]        init_cmd;
  logic [BANK_W-1:0] init_bank;
  logic [ADDR_W-1:0] init_addr;
  logic              init_end = 1'b0;
  logic              atref_req = 1'b0, atref_end = 1'b0;
  logic [3:0]        atref_cmd;
  logic [BANK_W-1:0] atref_bank;
  logic [ADDR_W-1:0] atref_addr;
  logic              wr_req = 1'b0, wr_end = 1'b0;
  logic [3:0]        wr_sdram_cmd;
  logic [BANK_W-1:0] wr_sdram_bank;
  logic [ADDR_W-1:0] wr_sdram_addr;
  logic              wr_sdram_en = 1'b0;
  logic [DATA_W-1:0] wr_sdram_data = '0;
  logic              rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]        rd_sdram_cmd;
  logic [BANK_W-1:0] rd_sdram_bank;
  logic [ADDR_W-1:0] rd_sdram_addr;

  assign {init_cmd, init_bank, init_addr}             = BUS_INIT;
  assign {atref_cmd, atref_bank, atref_addr}          = BUS_AREF;
  assign {wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr} = BUS_WR;
  assign {rd_sdram_cmd, rd_sdram_bank, rd_sdram_addr} = BUS_RD;

  logic              atref_en_f, wr_en_f, rd_en_f, oe_f, err_f;
  logic [3:0]        cmd_f;
  logic [BANK_W-1:0] bank_f;
  logic [ADDR_W-1:0] addr_f;
  logic [DATA_W-1:0] dq_f;
  logic              atref_en_r, wr_en_r, rd_en_r, oe_r, err_r;
  logic [3:0]        cmd_r;
  logic [BANK_W-1:0] bank_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] dq_r;

  logic [3:0]  stat_f, stat_r;
  logic [17:0] bus_f, bus_r;
  assign stat_f = {atref_en_f, wr_en_f, rd_en_f, err_f};
  assign stat_r = {atref_en_r, wr_en_r, rd_en_r, err_r};
  assign bus_f  = {cmd_f, bank_f, addr_f};
  assign bus_r  = {cmd_r, bank_r, addr_r};

  sdram_pro_arbiter #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DATA_W(DATA_W),
                      .PRIO_MODE(0), .TIMEOUT(16)) u_fix (
    .sys_clk(clk), .sys_rst(sys_rst),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr), .init_end(init_end),
    .atref_req(atref_req), .atref_end(atref_end),
    .atref_cmd(atref_cmd), .atref_bank(atref_bank), .atref_addr(atref_addr),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_sdram_cmd(wr_sdram_cmd), .wr_sdram_bank(wr_sdram_bank), .wr_sdram_addr(wr_sdram_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_sdram_cmd(rd_sdram_cmd), .rd_sdram_bank(rd_sdram_bank), .rd_sdram_addr(rd_sdram_addr),
    .atref_en(atref_en_f), .wr_en(wr_en_f), .rd_en(rd_en_f),
    .sdram_cmd(cmd_f), .sdram_bank(bank_f), .sdram_addr(addr_f),
    .sdram_dq_out(dq_f), .sdram_dq_oe(oe_f), .arb_err(err_f)
  );

  sdram_pro_arbiter #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DATA_W(DATA_W),
                      .PRIO_MODE(1), .TIMEOUT(16)) u_rr (
    .sys_clk(clk), .sys_rst(sys_rst),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr), .init_end(init_end),
    .atref_req(atref_req), .atref_end(atref_end),
    .atref_cmd(atref_cmd), .atref_bank(atref_bank), .atref_addr(atref_addr),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_sdram_cmd(wr_sdram_cmd), .wr_sdram_bank(wr_sdram_bank), .wr_sdram_addr(wr_sdram_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_sdram_cmd(rd_sdram_cmd), .rd_sdram_bank(rd_sdram_bank), .rd_sdram_addr(rd_sdram_addr),
    .atref_en(atref_en_r), .wr_en(wr_en_r), .rd_en(rd_en_r),
    .sdram_cmd(cmd_r), .sdram_bank(bank_r), .sdram_addr(addr_r),
    .sdram_dq_out(dq_r), .sdram_dq_oe(oe_r), .arb_err(err_r)
  );

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    atref_req = 0; atref_end = 0; wr_req = 0; wr_end = 0;
    rd_req = 0; rd_end = 0; init_end = 0; wr_sdram_en = 0;
    sys_rst = 1;
    step();
    step();
    sys_rst = 0;
  endtask

  task automatic go_arb();
    init_end = 1;
    step();
    init_end = 0;
  endtask

  task automatic test_reset();
    sys_rst = 1;
    wr_sdram_en = 1;
    step();
    step();
    checks++;
    if (stat_f !== S_IDLE || stat_r !== S_IDLE) begin
      errors++;
      $display("FAIL reset_stat: got %b/%b expected %b", stat_f, stat_r, S_IDLE);
    end
    checks++;
    if (bus_f !== BUS_INIT || bus_r !== BUS_INIT) begin
      errors++;
      $display("FAIL reset_bus: got %h/%h expected %h", bus_f, bus_r, BUS_INIT);
    end
    checks++;
    if (oe_f !== 1'b0 || oe_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_oe: got %b/%b expected 0", oe_f, oe_r);
    end
    sys_rst = 0;
    wr_sdram_en = 0;
  endtask

  task automatic test_init();
    do_reset();
    repeat (99) step();
    checks++;
    if (bus_f !== BUS_INIT || bus_r !== BUS_INIT) begin
      errors++;
      $display("FAIL init_pass: got %h/%h expected %h", bus_f, bus_r, BUS_INIT);
    end
    step();
    init_end = 1;
    step();
    checks++;
    if (bus_f !== BUS_NOP || bus_r !== BUS_NOP || stat_f !== S_IDLE || stat_r !== S_IDLE) begin
      errors++;
      $display("FAIL init_to_arb: got %h/%h expected %h", bus_f, bus_r, BUS_NOP);
    end
    init_end = 0;
    repeat (3) step();
    checks++;
    if (bus_f !== BUS_NOP || bus_r !== BUS_NOP) begin
      errors++;
      $display("FAIL init_end_ignored: got %h/%h expected %h", bus_f, bus_r, BUS_NOP);
    end
  endtask

  task automatic test_refresh_first();
    do_reset();
    atref_req = 1;
    wr_req = 1;
    go_arb();
    step();
    checks++;
    if (stat_f !== S_AREF || stat_r !== S_AREF || bus_f !== BUS_AREF) begin
      errors++;
      $display("FAIL aref_first: got %b/%b bus %h expected %b bus %h", stat_f, stat_r, bus_f, S_AREF, BUS_AREF);
    end
    atref_req = 0;
    rd_end = 1;
    wr_end = 1;
    step();
    rd_end = 0;
    wr_end = 0;
    checks++;
    if (stat_f !== S_AREF || stat_r !== S_AREF) begin
      errors++;
      $display("FAIL foreign_end_ignored: got %b/%b expected %b", stat_f, stat_r, S_AREF);
    end
    atref_end = 1;
    step();
    atref_end = 0;
    checks++;
    if (stat_f !== S_IDLE || stat_r !== S_IDLE || bus_f !== BUS_NOP) begin
      errors++;
      $display("FAIL aref_done_arb: got %b/%b bus %h expected %b", stat_f, stat_r, bus_f, S_IDLE);
    end
    step();
    checks++;
    if (stat_f !== S_WR || stat_r !== S_WR || bus_f !== BUS_WR || bus_r !== BUS_WR) begin
      errors++;
      $display("FAIL write_after_aref: got %b/%b bus %h expected %b bus %h", stat_f, stat_r, bus_f, S_WR, BUS_WR);
    end
    wr_req = 0;
    wr_end = 1;
    step();
    wr_end = 0;
    step();
    checks++;
    if (stat_f !== S_IDLE || stat_r !== S_IDLE || bus_r !== BUS_NOP) begin
      errors++;
      $display("FAIL idle_after_write: got %b/%b expected %b", stat_f, stat_r, S_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_r;
    do_reset();
    wr_req = 1;
    rd_req = 1;
    go_arb();
    for (int i = 0; i < 4; i++) begin
      step();
      exp_r = (i % 2 == 0) ? S_WR : S_RD;
      checks++;
      if (stat_f !== S_WR || stat_r !== exp_r) begin
        errors++;
        $display("FAIL burst%0d_grant: got %b/%b expected %b/%b", i, stat_f, stat_r, S_WR, exp_r);
      end
      checks++;
      if (bus_r !== ((i % 2 == 0) ? BUS_WR : BUS_RD)) begin
        errors++;
        $display("FAIL burst%0d_bus: got %h expected %h", i, bus_r, (i % 2 == 0) ? BUS_WR : BUS_RD);
      end
      step();
      wr_end = 1;
      rd_end = 1;
      step();
      wr_end = 0;
      rd_end = 0;
      checks++;
      if (stat_f !== S_IDLE || stat_r !== S_IDLE) begin
        errors++;
        $display("FAIL burst%0d_arb: got %b/%b expected %b", i, stat_f, stat_r, S_IDLE);
      end
    end
    wr_req = 0;
    rd_req = 0;
  endtask

  task automatic test_refresh_mid_write();
    do_reset();
    wr_req = 1;
    go_arb();
    step();
    wr_req = 0;
    for (int i = 0; i < 9; i++) begin
      wr_sdram_en = 1;
      wr_sdram_data = DATA_W'(i);
      if (i == 3) atref_req = 1;
      if (i == 8) wr_end = 1;
      #1;
      checks++;
      if (dq_f !== DATA_W'(i) || dq_r !== DATA_W'(i) || oe_f !== 1'b1 || oe_r !== 1'b1) begin
        errors++;
        $display("FAIL wdata%0d: got %h/%h oe %b/%b expected %h oe 1", i, dq_f, dq_r, oe_f, oe_r, i);
      end
      if (i >= 4) begin
        checks++;
        if (stat_f !== S_WR || stat_r !== S_WR) begin
          errors++;
          $display("FAIL no_preempt%0d: got %b/%b expected %b", i, stat_f, stat_r, S_WR);
        end
      end
      step();
    end
    wr_end = 0;
    checks++;
    if (stat_f !== S_IDLE || oe_f !== 1'b0 || oe_r !== 1'b0) begin
      errors++;
      $display("FAIL oe_outside_write: got stat %b oe %b/%b expected %b oe 0", stat_f, oe_f, oe_r, S_IDLE);
    end
    wr_sdram_en = 0;
    step();
    checks++;
    if (stat_f !== S_AREF || stat_r !== S_AREF) begin
      errors++;
      $display("FAIL aref_after_write: got %b/%b expected %b", stat_f, stat_r, S_AREF);
    end
    atref_req = 0;
    atref_end = 1;
    step();
    atref_end = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    wr_req = 1;
    go_arb();
    step();
    wr_req = 0;
    for (int k = 1; k < 16; k++) begin
      step();
      checks++;
      if (stat_f !== S_WR || stat_r !== S_WR) begin
        errors++;
        $display("FAIL hold_cycle%0d: got %b/%b expected %b", k, stat_f, stat_r, S_WR);
      end
    end
    step();
    checks++;
    if (stat_f !== S_ERR || stat_r !== S_ERR || bus_f !== BUS_NOP) begin
      errors++;
      $display("FAIL timeout_drop: got %b/%b expected %b", stat_f, stat_r, S_ERR);
    end
    rd_req = 1;
    step();
    step();
    rd_req = 0;
    checks++;
    if (stat_f !== (S_RD | S_ERR) || stat_r !== (S_RD | S_ERR)) begin
      errors++;
      $display("FAIL err_sticky: got %b/%b expected %b", stat_f, stat_r, S_RD | S_ERR);
    end
    rd_end = 1;
    step();
    rd_end = 0;
    do_reset();
    checks++;
    if (err_f !== 1'b0 || err_r !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: got %b/%b expected 0", err_f, err_r);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    rd_req = 1;
    go_arb();
    step();
    checks++;
    if (stat_f !== S_RD || stat_r !== S_RD || bus_f !== BUS_RD) begin
      errors++;
      $display("FAIL read_grant: got %b/%b bus %h expected %b bus %h", stat_f, stat_r, bus_f, S_RD, BUS_RD);
    end
    step();
    sys_rst = 1;
    wr_sdram_en = 1;
    step();
    sys_rst = 0;
    checks++;
    if (stat_f !== S_IDLE || stat_r !== S_IDLE || bus_f !== BUS_INIT || bus_r !== BUS_INIT || oe_f !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: got %b/%b bus %h oe %b expected %b bus %h oe 0", stat_f, stat_r, bus_f, oe_f, S_IDLE, BUS_INIT);
    end
    rd_end = 1;
    step();
    rd_end = 0;
    step();
    checks++;
    if (stat_f !== S_IDLE || stat_r !== S_IDLE || bus_r !== BUS_INIT) begin
      errors++;
      $display("FAIL stay_init: got %b/%b bus %h expected %b bus %h", stat_f, stat_r, bus_r, S_IDLE, BUS_INIT);
    end
    rd_req = 0;
    wr_sdram_en = 0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_refresh_first();
    test_back_to_back();
    test_refresh_mid_write();
    test_timeout();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
